ahb_master_fsm: RTL and testbench
=================================

AHB_MASTER_FSM -- requirements
Module: ahb_master_fsm

Interface
REQ-001 Parameter SEL_BIT, default 16: haddr bit used as slave select; 0 selects slave 1, 1 selects slave 2.
REQ-002 Parameter TIMEOUT, default 255: maximum data-phase wait cycles before forced error completion; range 1..255.
REQ-003 hclk  input  1  sole clock; all logic on rising edge.
REQ-004 hreset  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  32  transfer address.
REQ-009 cmd_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  8  read data; valid with rsp_valid on reads.
REQ-012 rsp_err  output  1  error flag; valid with rsp_valid.
REQ-013 haddr  output  32  AHB address.
REQ-014 htrans  output  2  AHB transfer type, IDLE = 2'b00 or NONSEQ = 2'b10 only.
REQ-015 hwrite  output  1  AHB direction.
REQ-016 hsize  output  3  constant 3'b000 (byte).
REQ-017 hwdata  output  8  AHB write data.
REQ-018 sel  output  1  data-phase slave select to the response multiplexor.
REQ-019 hrdata  input  8  multiplexed read data.
REQ-020 hreadyout  input  1  multiplexed ready.
REQ-021 hresp  input  1  multiplexed response, 1 = ERROR.

Function
REQ-022 States SHALL be IDLE, ADDR, DATA and RESP; the design issues single non-pipelined transfers only.
REQ-023 IDLE: cmd_ready=1 and htrans=IDLE; cmd_valid=1 latches cmd_write, cmd_addr and cmd_wdata, then goes to ADDR.
REQ-024 cmd_ready SHALL be 0 in every state other than IDLE.
REQ-025 ADDR (exactly 1 cycle): htrans=NONSEQ, haddr=latched address, hwrite=latched direction; sel<=latched address[SEL_BIT]; clear the wait counter and sticky error; go to DATA.
REQ-026 DATA: htrans=IDLE; hwdata=latched write data; haddr and hwrite hold their values; sel holds its value.
REQ-027 In DATA, hreadyout=1 completes the transfer: capture hrdata (on reads) and hresp into the response registers, then go to RESP.
REQ-028 In DATA, hreadyout=0 with hresp=1 sets a sticky error flag.
REQ-029 In DATA, each hreadyout=0 cycle increments an 8-bit wait counter.
REQ-030 When the wait counter equals TIMEOUT and hreadyout=0, go to RESP with rsp_err=1 and rsp_rdata=8'h00.
REQ-031 rsp_err SHALL equal the sticky error flag OR hresp sampled at completion, OR the timeout condition.
REQ-032 RESP (exactly 1 cycle): rsp_valid=1; go to IDLE.
REQ-033 rsp_rdata and rsp_err SHALL hold their values until the next completion.
REQ-034 Write completions SHALL leave rsp_rdata unchanged.
REQ-035 Latency: command accepted at cycle N; NONSEQ at N+1; DATA at N+2; with zero wait states, rsp_valid at N+3; next command accepted at N+4.
REQ-036 hwdata SHALL be 8'h00 outside DATA.
REQ-037 haddr and hwrite SHALL retain their last values in IDLE.

Reset
REQ-038 hreset=1 at any clock edge forces IDLE and aborts any in-flight transfer with no rsp_valid.
REQ-039 Reset values SHALL be: htrans=2'b00, haddr=0, hwrite=0, hwdata=0, sel=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, sticky error=0.
REQ-040 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-041 Read from 32'h0000_0004, hreadyout=1, hrdata=8'hA5 -> NONSEQ one cycle after accept, sel=0, rsp_valid 3 cycles after accept, rsp_rdata=8'hA5, rsp_err=0.
REQ-042 Write 8'h3C to 32'h0001_0000, 2 wait states -> sel=1 through DATA, hwdata=8'h3C, rsp_valid 5 cycles after accept, rsp_err=0.
REQ-043 Read with two-cycle error (hresp=1 & hreadyout=0, then hresp=1 & hreadyout=1) -> rsp_err=1 and the FSM returns to IDLE.
REQ-044 hreadyout held 0 with TIMEOUT=4 -> rsp_valid after 4 wait cycles, rsp_err=1, rsp_rdata=8'h00.
REQ-045 hreset asserted mid-DATA -> next cycle htrans=0, cmd_ready=1, no rsp_valid pulse, and all outputs at reset values.
REQ-046 cmd_valid held high continuously -> cmd_ready pulses once every 4 cycles with zero wait states, and no command is accepted outside IDLE.

Source files
------------

// File: rtl/ahb_master_fsm.sv
// ahb_master_fsm: single-transfer, non-pipelined AHB-Lite master.
// A command accepted in IDLE becomes one NONSEQ byte transfer (ADDR phase, then
// DATA phase with wait states). Its result comes back as a one-cycle rsp_valid pulse.
//
// Ports
//   hclk, hreset                   clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata  command handshake and payload
//   rsp_valid/rdata/err            completion pulse, held read data and error
//   haddr/htrans/hwrite/hsize/hwdata  AHB address/control/write-data outputs
//   sel                            data-phase slave select (haddr[SEL_BIT])
//   hrdata/hreadyout/hresp         multiplexed slave response inputs
module ahb_master_fsm #(
   parameter int unsigned SEL_BIT = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] haddr,
   output logic [1:0]  htrans,
   output logic        hwrite,
   output logic [2:0]  hsize,
   output logic [7:0]  hwdata,
   output logic        sel,
   input  logic [7:0]  hrdata,
   input  logic        hreadyout,
   input  logic        hresp
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransNonseq = 2'b10;

   typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        write_q, write_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        sel_q, sel_d;
   logic [7:0]  wait_q, wait_d;
   logic        sticky_q, sticky_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        err_q, err_d;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         sel_q    <= 1'b0;
         wait_q   <= '0;
         sticky_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         sel_q    <= sel_d;
         wait_q   <= wait_d;
         sticky_q <= sticky_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      wait_d    = wait_q;
      sticky_d  = sticky_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cmd_ready = 1'b0;
      htrans    = TransIdle;
      rsp_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               write_d = cmd_write;
               wdata_d = cmd_wdata;
               state_d = StAddr;
            end
         end
         StAddr: begin
            htrans   = TransNonseq;
            sel_d    = addr_q[SEL_BIT];
            wait_d   = '0;
            sticky_d = 1'b0;
            state_d  = StData;
         end
         StData: begin
            if (hreadyout) begin
               // Ready wins even on the cycle the counter reaches TIMEOUT.
               if (!write_q) rdata_d = hrdata;
               err_d   = sticky_q | hresp;
               state_d = StResp;
            end else if (wait_q == TimeoutCnt) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               wait_d = wait_q + 8'd1;
               if (hresp) sticky_d = 1'b1;
            end
         end
         StResp: begin
            rsp_valid = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign haddr     = addr_q;
   assign hwrite    = write_q;
   assign hsize     = 3'b000;
   assign hwdata    = (state_q == StData) ? wdata_q : 8'h00;
   assign sel       = sel_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_ahb_master_fsm.sv
// tb_ahb_master_fsm: directed bench for ahb_master_fsm (SEL_BIT=16, TIMEOUT=4).
// A transaction-level model sets the expected outputs for every cycle, and a
// negedge compare process checks all DUT outputs against them.
module tb_ahb_master_fsm;

   localparam int unsigned TO = 4;

   logic        hclk = 1'b0;
   logic        hreset, cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, haddr;
   logic [7:0]  cmd_wdata, rsp_rdata, hwdata, hrdata;
   logic        rsp_valid, rsp_err, hwrite, sel, hreadyout, hresp;
   logic [1:0]  htrans;
   logic [2:0]  hsize;

   always #5 hclk = ~hclk;

   ahb_master_fsm #(.SEL_BIT(16), .TIMEOUT(TO)) dut (
      .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .sel(sel),
      .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
   );

   int checks = 0;
   int failures = 0;

   // Expected outputs for the current cycle
   logic        e_cmd_ready, e_hwrite, e_sel, e_rsp_valid, e_err;
   logic [1:0]  e_htrans;
   logic [31:0] e_haddr;
   logic [7:0]  e_hwdata, e_rdata;
   bit          chk_en = 0;

   // Model state that persists across transactions
   logic [31:0] m_haddr;
   logic        m_hwrite, m_sel, m_err;
   logic [7:0]  m_rdata;

   // Measurements taken from the DUT handshake
   int cyc = 0, acc_cyc = -1, acc_gap = -1, lat = -1, acc_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge hclk) begin
      cyc++;
      if (chk_en) begin
         check("cmd_ready", cmd_ready, e_cmd_ready);
         check("htrans", htrans, e_htrans);
         check("haddr", haddr, e_haddr);
         check("hwrite", hwrite, e_hwrite);
         check("hsize", hsize, 3'b000);
         check("hwdata", hwdata, e_hwdata);
         check("sel", sel, e_sel);
         check("rsp_valid", rsp_valid, e_rsp_valid);
         check("rsp_rdata", rsp_rdata, e_rdata);
         check("rsp_err", rsp_err, e_err);
         if (cmd_valid && cmd_ready) begin
            if (acc_cyc >= 0) acc_gap = cyc - acc_cyc;
            acc_cyc = cyc;
            acc_cnt++;
         end
         if (rsp_valid) lat = cyc - acc_cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic base_exp();
      e_cmd_ready = 1'b1;
      e_htrans    = 2'b00;
      e_haddr     = m_haddr;
      e_hwrite    = m_hwrite;
      e_hwdata    = 8'h00;
      e_sel       = m_sel;
      e_rsp_valid = 1'b0;
      e_rdata     = m_rdata;
      e_err       = m_err;
   endtask

   task automatic idle_slave();
      hreadyout = 1'b1;
      hresp     = 1'b0;
      hrdata    = 8'hEE;
   endtask

   task automatic idle_cycle();
      tick();
      base_exp();
      cmd_valid = 1'b0;
      idle_slave();
   endtask

   // Outside IDLE the command bus carries junk that must never be latched.
   task automatic junk_cmd(input bit hold, input logic wr, input logic [31:0] a,
                           input logic [7:0] wd);
      cmd_valid = hold;
      cmd_write = ~wr;
      cmd_addr  = ~a;
      cmd_wdata = ~wd;
   endtask

   // One transfer: nwait cycles with hreadyout=0 (hresp=resp_wait), then a ready
   // cycle (hresp=resp_done, hrdata=rd), cut short by the timeout rule.
   task automatic txn(input logic wr, input logic [31:0] a, input logic [7:0] wd,
                      input int nwait, input logic resp_wait, input logic resp_done,
                      input logic [7:0] rd, input bit hold);
      logic sticky;
      bit   done;
      int   k;
      tick();
      base_exp();
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      idle_slave();
      m_haddr = a;
      m_hwrite = wr;
      tick();
      base_exp();
      e_cmd_ready = 1'b0;
      e_htrans = 2'b10;
      junk_cmd(hold, wr, a, wd);
      m_sel = a[16];
      sticky = 1'b0;
      k = 0;
      done = 0;
      while (!done) begin
         tick();
         base_exp();
         e_cmd_ready = 1'b0;
         e_hwdata = wd;
         junk_cmd(hold, wr, a, wd);
         hreadyout = (k >= nwait);
         hresp     = (k < nwait) ? resp_wait : resp_done;
         hrdata    = (k >= nwait) ? rd : 8'hEE;
         if (k >= nwait) begin
            m_err = sticky | resp_done;
            if (!wr) m_rdata = rd;
            done = 1;
         end else if (k == TO) begin
            m_err = 1'b1;
            m_rdata = 8'h00;
            done = 1;
         end else begin
            sticky = sticky | resp_wait;
            k++;
         end
      end
      tick();
      base_exp();
      e_cmd_ready = 1'b0;
      e_rsp_valid = 1'b1;
      junk_cmd(hold, wr, a, wd);
      idle_slave();
   endtask

   initial begin
      int acc_before;
      hreset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      idle_slave();
      m_haddr = '0; m_hwrite = 1'b0; m_sel = 1'b0; m_rdata = '0; m_err = 1'b0;
      tick();
      base_exp();
      chk_en = 1;
      tick();
      base_exp();
      hreset = 1'b0;
      tick();
      base_exp();
      check("reset_cmd_ready_first", cmd_ready, 1'b1);
      check("reset_haddr", haddr, 32'h0);

      // Zero-wait read from slave 1
      txn(1'b0, 32'h0000_0004, 8'h00, 0, 1'b0, 1'b0, 8'hA5, 0);
      idle_cycle();
      check("read_latency", lat, 3);
      check("read_rdata", rsp_rdata, 8'hA5);
      check("read_err", rsp_err, 1'b0);

      // Write to slave 2 with two wait states
      txn(1'b1, 32'h0001_0000, 8'h3C, 2, 1'b0, 1'b0, 8'h77, 0);
      idle_cycle();
      check("write_latency", lat, 5);
      check("write_keeps_rdata", rsp_rdata, 8'hA5);
      check("write_sel", sel, 1'b1);
      check("write_haddr_held", haddr, 32'h0001_0000);

      // Two-cycle error response
      txn(1'b0, 32'h0000_0010, 8'h00, 1, 1'b1, 1'b1, 8'h99, 0);
      idle_cycle();
      check("err2_err", rsp_err, 1'b1);
      check("err2_idle", cmd_ready, 1'b1);

      // Error seen only while waiting still sticks
      txn(1'b0, 32'h0000_0020, 8'h00, 3, 1'b1, 1'b0, 8'h42, 0);
      idle_cycle();
      check("sticky_err", rsp_err, 1'b1);
      check("sticky_rdata", rsp_rdata, 8'h42);

      // Sticky flag cleared by the next transfer
      txn(1'b0, 32'h0001_0030, 8'h00, 0, 1'b0, 1'b0, 8'h11, 0);
      idle_cycle();
      check("clean_err", rsp_err, 1'b0);

      // Timeout: hreadyout never rises
      txn(1'b0, 32'h0000_0040, 8'h00, 20, 1'b0, 1'b0, 8'hFF, 0);
      idle_cycle();
      check("timeout_err", rsp_err, 1'b1);
      check("timeout_rdata", rsp_rdata, 8'h00);
      check("timeout_latency", lat, 7);

      // Ready arriving on the cycle the counter reaches TIMEOUT completes normally
      txn(1'b0, 32'h0000_0044, 8'h00, 4, 1'b0, 1'b0, 8'h66, 0);
      idle_cycle();
      check("edge_err", rsp_err, 1'b0);
      check("edge_rdata", rsp_rdata, 8'h66);

      // Reset mid-DATA, with a completing response on the reset cycle
      tick();
      base_exp();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0001_0008; cmd_wdata = 8'hC3;
      idle_slave();
      m_haddr = 32'h0001_0008;
      m_hwrite = 1'b1;
      tick();
      base_exp();
      e_cmd_ready = 1'b0;
      e_htrans = 2'b10;
      cmd_valid = 1'b0;
      m_sel = 1'b1;
      tick();
      base_exp();
      e_cmd_ready = 1'b0;
      e_hwdata = 8'hC3;
      hreadyout = 1'b0;
      hresp = 1'b0;
      tick();
      base_exp();
      e_cmd_ready = 1'b0;
      e_hwdata = 8'hC3;
      hreadyout = 1'b1;
      hresp = 1'b1;
      hreset = 1'b1;
      tick();
      hreset = 1'b0;
      m_haddr = '0; m_hwrite = 1'b0; m_sel = 1'b0; m_rdata = '0; m_err = 1'b0;
      base_exp();
      idle_slave();
      check("rst_htrans", htrans, 2'b00);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rdata", rsp_rdata, 8'h00);
      check("rst_haddr", haddr, 32'h0);

      // cmd_valid held high: one accept per four cycles
      acc_gap = -1;
      acc_before = acc_cnt;
      txn(1'b0, 32'h0000_0050, 8'h00, 0, 1'b0, 1'b0, 8'h21, 1);
      txn(1'b1, 32'h0001_0054, 8'hAB, 0, 1'b0, 1'b0, 8'h00, 1);
      txn(1'b0, 32'h0000_0058, 8'h00, 0, 1'b0, 1'b0, 8'h34, 1);
      idle_cycle();
      check("b2b_gap", acc_gap, 4);
      check("b2b_accepts", acc_cnt - acc_before, 3);
      check("b2b_rdata", rsp_rdata, 8'h34);

      idle_cycle();
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
